// File: rtl/mem_line_if.sv
// Cache-line transfer bundle between a cache, the line responder and a
// single-ported word memory. The slave modport is the responder's view;
// the master modport is the cache/memory environment's view.
interface mem_line_if #(
  parameter int AW = 30
);
  // Cache request side
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  // Writeback data path (cache presents wr_data for wr_word_idx)
  logic [2:0]    wr_word_idx;
  logic [31:0]   wr_data;
  // Fill data path
  logic          rd_valid;
  logic [2:0]    rd_word_idx;
  logic [31:0]   rd_data;
  logic          done;
  // Memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, wr_data, mem_rdata,
    output req_ready, wr_word_idx, rd_valid, rd_word_idx, rd_data, done,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, wr_data, mem_rdata,
    input  req_ready, wr_word_idx, rd_valid, rd_word_idx, rd_data, done,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_line_responder.sv
// Moves one 8-word cache line between a cache and a word memory.
// Writebacks stream words 0..7 straight from the cache to memory; fills
// issue 8 reads and forward each word to the cache the cycle after.
// Optional feature: define MEM_RESP_CWF_EN for critical-word-first fills
// (fill order starts at req_addr[2:0]); otherwise fills run 0..7.
module mem_line_responder #(
  parameter int AW = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_line_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    READ_TAIL = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    k_q, k_d;            // beat counter
  logic [2:0]    start_q, start_d;    // first word of a fill
  logic [AW-4:0] line_q, line_d;      // latched line address
  logic          rd_valid_q;
  logic [2:0]    rd_idx_q;
  logic [2:0]    rd_idx;

  // Fill word index wraps within the line (7 + 1 = 0).
  assign rd_idx = start_q + k_q;

`ifndef MEM_RESP_CWF_EN
  // Word-select bits of the request address play no part without CWF.
  logic unused_word_sel;
  assign unused_word_sel = ^bus.req_addr[2:0];
`endif

  // State, beat counter and request latches.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      start_q <= 3'd0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      start_q <= start_d;
      line_q  <= line_d;
    end
  end

  // Fill delivery: memory answers one cycle after a read beat, so the slot
  // index and valid flag are delayed by one register stage to line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_idx_q   <= 3'd0;
    end else begin
      rd_valid_q <= (state_q == READ);
      rd_idx_q   <= (state_q == READ) ? rd_idx : 3'd0;
    end
  end

  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_word_idx = rd_idx_q;
  assign bus.rd_data     = rd_valid_q ? bus.mem_rdata : 32'd0;

  // Next-state logic and memory/handshake outputs.
  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    start_d         = start_q;
    line_d          = line_q;
    bus.req_ready   = 1'b0;
    bus.wr_word_idx = 3'd0;
    bus.done        = 1'b0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = 32'd0;

    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          line_d  = bus.req_addr[AW-1:3];
          k_d     = 3'd0;
`ifdef MEM_RESP_CWF_EN
          start_d = bus.req_write ? 3'd0 : bus.req_addr[2:0];
`else
          start_d = 3'd0;
`endif
          state_d = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.mem_en      = 1'b1;
        bus.mem_we      = 1'b1;
        bus.wr_word_idx = k_q;
        bus.mem_addr    = {line_q, k_q};
        bus.mem_wdata   = bus.wr_data;
        k_d             = k_q + 3'd1;
        if (k_q == 3'd7) state_d = DONE;
      end
      READ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {line_q, rd_idx};
        k_d          = k_q + 3'd1;
        if (k_q == 3'd7) state_d = READ_TAIL;
      end
      READ_TAIL: begin
        state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: expected memory writes and fill
// words are queued when a request is issued and popped as the DUT emits them.
// A small word memory model answers reads one cycle after the read beat.
module tb_mem_line_responder;

  localparam int AW = 30;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_beat_t;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } rd_beat_t;

  logic clk;
  logic rst_n;
  logic [31:0] wr_base;

  mem_line_if #(.AW(AW)) bus ();

  mem_line_responder #(.AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache side: writeback word is a function of the requested index.
  assign bus.wr_data = wr_base + {29'd0, bus.wr_word_idx};

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  wr_beat_t wr_exp[$];
  rd_beat_t rd_exp[$];
  logic [31:0] ref_mem [0:4095];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word memory model; unwritten words read back as 0xB0 + word offset.
  logic [31:0] mem_model [0:4095];
  bit          mem_written [0:4095];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem_model[bus.mem_addr[11:0]]   <= bus.mem_wdata;
        mem_written[bus.mem_addr[11:0]] <= 1'b1;
      end else begin
        bus.mem_rdata <= mem_written[bus.mem_addr[11:0]] ?
                         mem_model[bus.mem_addr[11:0]] :
                         32'hB0 + {29'd0, bus.mem_addr[2:0]};
      end
    end
  end

  // Output monitor: pops scoreboard entries as beats appear.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_en && bus.mem_we) begin
        if (wr_exp.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          wr_beat_t e;
          e = wr_exp.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
        end
      end
      if (bus.rd_valid) begin
        if (rd_exp.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          rd_beat_t r;
          r = rd_exp.pop_front();
          check("rd_idx", bus.rd_word_idx, r.idx);
          check("rd_data", bus.rd_data, r.data);
        end
      end
      if (bus.done) done_cnt++;
    end
  end

  // Queue the expected beats of a transfer and update the reference memory.
  task automatic push_expect(input bit wr, input logic [AW-1:0] a, input int n_beats);
    logic [2:0]    s;
    logic [2:0]    idx;
    logic [AW-1:0] wa;
    s = 3'd0;
`ifdef MEM_RESP_CWF_EN
    if (!wr) s = a[2:0];
`endif
    for (int k = 0; k < n_beats; k++) begin
      if (wr) begin
        wa = {a[AW-1:3], 3'(k)};
        wr_exp.push_back('{addr: wa, data: wr_base + 32'(k)});
        ref_mem[wa[11:0]] = wr_base + 32'(k);
      end else begin
        idx = s + 3'(k);
        wa  = {a[AW-1:3], idx};
        rd_exp.push_back('{idx: idx, data: ref_mem[wa[11:0]]});
      end
    end
  endtask

  // Issue one request at a negedge in IDLE and follow it to completion,
  // checking per-cycle handshake timing. With hold set, req_valid stays
  // high throughout so the next request is presented while busy.
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input bit hold);
    int lat;
    int n;
    lat = wr ? 9 : 10;
    push_expect(wr, a, 8);
    exp_done++;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", n, 0);
    for (int w = 1; w <= lat + 1; w++) begin
      @(negedge clk);
      check("done", bus.done, (w == lat));
      check("req_ready", bus.req_ready, (w == lat + 1));
      if (wr) check("mem_we", bus.mem_we, (w <= 8));
      else    check("rd_valid", bus.rd_valid, (w >= 2 && w <= 9));
      if (w == 1 && !hold) bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    int d0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'hB0 + 32'(i % 8);
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    wr_base       = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", bus.req_ready, 1);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_rd_idx", bus.rd_word_idx, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_idx", bus.wr_word_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Writeback of line 0x100 with 0xA0+idx
    wr_base = 32'hA0;
    do_req(1'b1, 30'h100, 1'b0);

    // Fill of 0x205 (order depends on critical-word-first build)
    do_req(1'b0, 30'h205, 1'b0);

    // Request held high while busy: ignored, then accepted right after done
    do_req(1'b0, 30'h205, 1'b1);
    do_req(1'b0, 30'h205, 1'b0);

    // Reset during write beat 3 aborts the writeback
    wr_base = 32'hD0;
    push_expect(1'b1, 30'h500, 3);
    bus.req_write = 1'b1;
    bus.req_addr  = 30'h500;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mem_we", bus.mem_we, 0);
    check("abort_mem_en", bus.mem_en, 0);
    check("abort_ready", bus.req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_after", bus.req_ready, 1);
    check("abort_no_done", done_cnt, d0);
    do_req(1'b1, 30'h500, 1'b0);

    // Writeback then immediate fill of the same line
    wr_base = 32'hC0;
    do_req(1'b1, 30'h300, 1'b0);
    do_req(1'b0, 30'h300, 1'b0);

    repeat (3) @(negedge clk);
    check("wr_queue_empty", wr_exp.size(), 0);
    check("rd_queue_empty", rd_exp.size(), 0);
    check("done_count", done_cnt, exp_done);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
